// File: rtl/sdp_ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_fifo_ctrl_if
// Brief    : Stream and RAM-port bundle for the RAM-backed FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sdp_ram_fifo_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 16
);
    localparam int c_AW = $clog2(ENTRIES);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [c_AW:0]    count;
    logic [c_AW-1:0]  ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_we;
    logic [c_AW-1:0]  ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    // Controller side
    modport slave (
        input  in_data, in_valid, out_ready, ram_rdata,
        output in_ready, out_data, out_valid, count,
               ram_waddr, ram_wdata, ram_we, ram_raddr
    );

    // Producer / consumer / RAM side
    modport master (
        output in_data, in_valid, out_ready, ram_rdata,
        input  in_ready, out_data, out_valid, count,
               ram_waddr, ram_wdata, ram_we, ram_raddr
    );
endinterface
`default_nettype wire

// File: rtl/sdp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_fifo_ctrl
// Brief    : First-word-fall-through FIFO controller driving an external
//            simple dual-port RAM with 1-cycle registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram_fifo_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sdp_ram_fifo_ctrl_if.slave fifo
);
    localparam int c_AW = $clog2(ENTRIES);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(ENTRIES);

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [c_CW-1:0]  w_count_less_pop;
    logic [WIDTH-1:0] w_wdata;

    assign w_in_ready       = !rst && (r_count != c_FULL);
    assign w_push           = fifo.in_valid & w_in_ready;
    assign w_pop            = r_out_valid & fifo.out_ready;
    assign w_count_less_pop = r_count - c_CW'(w_pop);
    assign w_wdata          = fifo.in_data;

    assign fifo.in_ready  = w_in_ready;
    assign fifo.out_valid = r_out_valid;
    assign fifo.out_data  = fifo.ram_rdata;
    assign fifo.count     = r_count;
    assign fifo.ram_we    = w_push;
    assign fifo.ram_waddr = r_wr_ptr;
    assign fifo.ram_wdata = w_wdata;
    // Prefetch the next head on a pop so the RAM's read latency is hidden.
    assign fifo.ram_raddr = w_pop ? (r_rd_ptr + c_AW'(1)) : r_rd_ptr;

    // A word only becomes visible once it was written in an earlier cycle;
    // this keeps the read address off a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count     <= w_count_less_pop + c_CW'(w_push);
            r_out_valid <= (w_count_less_pop != '0);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_ram_fifo_ctrl
// Brief    : Directed vector bench for sdp_ram_fifo_ctrl with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdp_ram_fifo_ctrl;
    localparam int c_WIDTH   = 8;
    localparam int c_ENTRIES = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sdp_ram_fifo_ctrl_if #(.WIDTH(c_WIDTH), .ENTRIES(c_ENTRIES)) bus ();

    sdp_ram_fifo_ctrl #(.WIDTH(c_WIDTH), .ENTRIES(c_ENTRIES)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    // Behavioural simple dual-port RAM, registered read.
    logic [c_WIDTH-1:0] mem [c_ENTRIES];
    logic [c_WIDTH-1:0] r_rdata;
    always_ff @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        r_rdata <= mem[bus.ram_raddr];
    end
    assign bus.ram_rdata = r_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_we;
        logic [3:0] e_waddr;
        logic [3:0] e_raddr;
        logic       e_ov;
        logic [7:0] e_data;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] exp_next;
        int         got;

        errors = 0;
        checks = 0;
        // iv d ordy | ir we waddr raddr ov data cnt
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 5'd0};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 5'd0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 8'h00, 5'd1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 8'hA5, 5'd1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 8'h00, 5'd0};
        tbl[5] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 8'h00, 5'd0};
        tbl[6] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 1'b0, 8'h00, 5'd1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 1'b1, 8'h5A, 5'd2};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b1, 8'hC3, 5'd1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 8'h00, 5'd0};

        // Reset with a pending producer word: nothing may be written.
        rst = 1'b1;
        drive(1'b1, 8'h11, 1'b0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_we", 32'(bus.ram_we), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_count", 32'(bus.count), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_we", i), 32'(bus.ram_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d_waddr", i), 32'(bus.ram_waddr), 32'(tbl[i].e_waddr));
            chk($sformatf("v%0d_raddr", i), 32'(bus.ram_raddr), 32'(tbl[i].e_raddr));
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_ov)
                chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
            if (tbl[i].e_we)
                chk($sformatf("v%0d_wdata", i), 32'(bus.ram_wdata), 32'(tbl[i].d));
        end

        // Fill to capacity with the consumer stalled; pointers start at 3.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, 8'(i), 1'b0);
            #1;
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            chk("fill_waddr", 32'(bus.ram_waddr), 32'((i + 3) % 16));
        end
        @(negedge clk);
        drive(1'b1, 8'hFF, 1'b0);
        #1;
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_we", 32'(bus.ram_we), 32'd0);
        chk("full_head", 32'(bus.out_data), 32'h00);

        // Pop while full: push must still be refused this cycle.
        @(negedge clk);
        drive(1'b1, 8'hEE, 1'b1);
        #1;
        chk("fullpop_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fullpop_we", 32'(bus.ram_we), 32'd0);
        chk("fullpop_data", 32'(bus.out_data), 32'h00);
        @(negedge clk);
        drive(1'b1, 8'hEF, 1'b0);
        #1;
        chk("afterpop_count", 32'(bus.count), 32'd15);
        chk("afterpop_we", 32'(bus.ram_we), 32'd1);
        chk("afterpop_head", 32'(bus.out_data), 32'h01);

        for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hEF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b0, 8'h00, 1'b1);
            #1;
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data", 32'(bus.out_data), 32'(exp_q[i]));
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        chk("drained_valid", 32'(bus.out_valid), 32'd0);
        chk("drained_count", 32'(bus.count), 32'd0);

        // Streaming through both pointer wraps.
        exp_next = 8'h00;
        got      = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            drive(1'b1, 8'(k), 1'b1);
            #1;
            if (k >= 2) chk("stream_valid", 32'(bus.out_valid), 32'd1);
            if (bus.out_valid) begin
                chk("stream_data", 32'(bus.out_data), 32'(exp_next));
                exp_next++;
                got++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b0, 8'h00, 1'b1);
            #1;
            if (bus.out_valid) begin
                chk("stream_tail", 32'(bus.out_data), 32'(exp_next));
                exp_next++;
                got++;
            end
        end
        chk("stream_words", 32'(got), 32'd40);

        // Asynchronous reset pulse mid-stream with 7 words stored.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, 8'h80 + 8'(i), 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 8'h99, 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("pre_rst_count", 32'(bus.count), 32'd7);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_we", 32'(bus.ram_we), 32'd0);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h3C, 1'b0);
        #1;
        chk("post_rst_we", 32'(bus.ram_we), 32'd1);
        chk("post_rst_waddr", 32'(bus.ram_waddr), 32'd0);
        chk("post_rst_raddr", 32'(bus.ram_raddr), 32'd0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        chk("post_rst_t1_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_t1_count", 32'(bus.count), 32'd1);
        @(negedge clk);
        #1;
        chk("post_rst_t2_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_t2_data", 32'(bus.out_data), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdp_ram_fifo_ctrl.md
Name: sdp_ram_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives one external simpleDualPortRam instance: it feeds the RAM's write port (waddr/writeData/writeEnable) and consumes its 1-cycle-latency registered readData.
- Presents valid/ready streams on input and output, with first-word-fall-through at full throughput.
- Sits between any producer stream and consumer stream that need RAM-backed buffering. Both RAM clocks are tied to clk.

Parameters:
- WIDTH, 8, word width; must match the RAM's WIDTH.
- ENTRIES, 16, RAM depth and FIFO capacity; power of two, ≥2, must match the RAM's ENTRIES.

Ports:
- clk  input  1  system clock; also drives RAM wclk and rclk.
- rst  input  1  reset; asynchronous, active-high.
- in_data  input  WIDTH  word to enqueue.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts a word this cycle.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  $clog2(ENTRIES)+1  words stored, 0..ENTRIES.
- ram_waddr  output  $clog2(ENTRIES)  to RAM waddr.
- ram_wdata  output  WIDTH  to RAM writeDate.
- ram_we  output  1  to RAM writeEnable.
- ram_raddr  output  $clog2(ENTRIES)  to RAM raddr.
- ram_rdata  input  WIDTH  from RAM readData.

Behaviour:
- State registers: wr_ptr and rd_ptr (each $clog2(ENTRIES) bits, natural wrap at ENTRIES), count, and out_valid.
- Reset (asynchronous, rst=1): wr_ptr=0, rd_ptr=0, count=0, out_valid=0. While rst=1, in_ready=0 and ram_we=0. RAM contents are not cleared. Asserting reset mid-stream discards all words, and no output handshake completes on the reset edge.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !rst & (count != ENTRIES). When full, a simultaneous pop does NOT enable a push in the same cycle.
- ram_we = push; ram_waddr = wr_ptr; ram_wdata = in_data; all combinational.
- ram_raddr = pop ? rd_ptr+1 : rd_ptr (combinational, wraps).
- out_data = ram_rdata, passed straight through with no extra register.
- Edge updates:
  - On push: wr_ptr++.
  - On pop: rd_ptr++.
  - count <= count + push - pop. Push and pop together leave count unchanged.
  - out_valid <= (count - pop) != 0.
- Why the out_valid rule holds: a word counts as readable only if it was stored before the current cycle. When count - pop == 0, ram_raddr equals wr_ptr, and any same-cycle write hits the RAM's undefined read-during-write case. out_valid stays 0 for that cycle.
- Latency:
  - Push into an empty FIFO at cycle t gives out_valid=1 at t+2.
  - Back-to-back pops sustain 1 word/cycle while count ≥ 2.
- Overwrite protection: the head slot is never overwritten while displayed. The full check prevents wr_ptr from reaching rd_ptr while the head is occupied.
- out_data/out_valid stability: held stable while out_valid=1 and out_ready=0.
- Pointer wrap: after ENTRIES pushes/pops, pointers roll from ENTRIES-1 to 0 with no bubble.

Test Plan:
- Reset then idle: count=0, out_valid=0, in_ready=1 after rst falls, ram_we=0 throughout.
- Single word from empty:
  - Push 0xA5 at cycle t.
  - Expect ram_we=1 and ram_waddr=0 at t; count=1 at t+1; out_valid=1 and out_data=0xA5 at t+2.
  - Pop at t+2 → out_valid=0 at t+3, count=0.
- Fill with ENTRIES=16 and out_ready=0:
  - Push 0x00..0x0F; in_ready=0 with count=16 after the 16th push.
  - A further in_valid is ignored (ram_we=0).
  - Drain yields 0x00..0x0F in order, one per cycle.
- Streaming: in_valid=out_ready=1 for 40 cycles with an incrementing pattern → after 2-cycle fill, out_data increments every cycle across both pointer wraps, with no gaps or duplicates.
- Full and pop together: at count=16, assert in_valid and out_ready together → pop occurs, push rejected, count=15; the next cycle's push is accepted.
- Reset mid-stream: with count=7, pulse rst asynchronously (between edges) → out_valid and count drop to 0 immediately. The next push of 0x3C appears as out_data at the 2-cycle latency from ram_raddr=0.
